// File: rtl/pal_pkg.sv
// Shared types and line-number tables for the PAL test-frame generator.
package pal_pkg;

    localparam logic [9:0] VC_LAST_I  = 10'd624;
    localparam logic [9:0] VC_LAST_P  = 10'd311;
    localparam logic [9:0] VC_FIELD2  = 10'd313;
    localparam logic [9:0] LN_PROG_EQ = 10'd309;

    typedef enum logic [2:0] {
        BROAD_BROAD,
        BROAD_EQ,
        EQ_BROAD,
        EQ_EQ,
        VISIBLE
    } sync_t;

    typedef enum logic [1:0] {
        PAT_BARS,
        PAT_RAMP,
        PAT_HATCH,
        PAT_WHITE
    } pat_t;

    // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [0:7][2:0] BAR_RGB = {3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

    function automatic sync_t sync_class(input logic [9:0] vc, input logic prog);
        sync_t c;
        c = VISIBLE;
        case (vc)
            10'd0, 10'd1, 10'd313, 10'd314:                  c = BROAD_BROAD;
            10'd2:                                           c = BROAD_EQ;
            10'd312:                                         c = EQ_BROAD;
            10'd3, 10'd4, 10'd310, 10'd311, 10'd315, 10'd316,
            10'd622, 10'd623, 10'd624:                       c = EQ_EQ;
            LN_PROG_EQ:                                      c = prog ? EQ_EQ : VISIBLE;
            default:                                         c = VISIBLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pal_pattern_gen.sv
// Combinational next-pixel generator; the top registers its outputs.
module pal_pattern_gen
    import pal_pkg::*;
#(
    parameter int CBITS = 3,
    parameter int BW    = 7
) (
    input  pat_t             pat_q,
    input  logic [2:0]       bar,
    input  logic [BW-1:0]    barsub,
    input  logic [3:0]       vc_lo,
    input  logic             videoen_next,
    output logic [CBITS-1:0] r_next,
    output logic [CBITS-1:0] g_next,
    output logic [CBITS-1:0] b_next
);

    logic [CBITS-1:0] grey;
    logic [CBITS-1:0] ones;

    assign ones = '1;

    // Low bits replicate bar[0] so bar 7 reaches full scale.
    if (CBITS > 3) begin : g_ext
        assign grey = {bar, {(CBITS-3){bar[0]}}};
    end else begin : g_min
        assign grey = bar;
    end

    always_comb begin
        r_next = '0;
        g_next = '0;
        b_next = '0;
        if (videoen_next) begin
            case (pat_q)
                PAT_BARS: begin
                    r_next = {CBITS{BAR_RGB[bar][2]}};
                    g_next = {CBITS{BAR_RGB[bar][1]}};
                    b_next = {CBITS{BAR_RGB[bar][0]}};
                end
                PAT_RAMP: begin
                    r_next = grey;
                    g_next = grey;
                    b_next = grey;
                end
                PAT_HATCH: begin
                    if (barsub == '0 || vc_lo == 4'd0) begin
                        r_next = ones;
                        g_next = ones;
                        b_next = ones;
                    end
                end
                PAT_WHITE: begin
                    r_next = ones;
                    g_next = ones;
                    b_next = ones;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pal_frame_gen.sv
// PAL test-frame generator: line/frame counters, CSYNC with broad/equalising
// pulses and a selectable RGB test pattern, all outputs registered.
module pal_frame_gen
    import pal_pkg::*;
#(
    parameter int CBITS      = 3,
    parameter int LINE_CLKS  = 640,
    parameter int HALF_CLKS  = 320,
    parameter int HSYNC_CLKS = 40,
    parameter int EQ_CLKS    = 20,
    parameter int BROAD_CLKS = 300,
    parameter int ACT_START  = 120,
    parameter int BAR_CLKS   = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [1:0]       pattern,
    output logic [CBITS-1:0] r,
    output logic [CBITS-1:0] g,
    output logic [CBITS-1:0] b,
    output logic             csync,
    output logic             videoen,
    output logic             field,
    output logic             frame_start
);

    localparam int HW = $clog2(LINE_CLKS);
    localparam int BW = (BAR_CLKS > 1) ? $clog2(BAR_CLKS) : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(LINE_CLKS - 1);
    localparam logic [HW-1:0] H_HALF  = HW'(HALF_CLKS);
    localparam logic [HW-1:0] H_SYNC  = HW'(HSYNC_CLKS);
    localparam logic [HW-1:0] H_EQ    = HW'(EQ_CLKS);
    localparam logic [HW-1:0] H_BROAD = HW'(BROAD_CLKS);
    localparam logic [HW-1:0] H_ACT   = HW'(ACT_START);
    localparam logic [BW-1:0] B_LAST  = BW'(BAR_CLKS - 1);

    logic [HW-1:0]    hc, hoff;
    logic [9:0]       vc;
    logic [2:0]       bar;
    logic [BW-1:0]    barsub;
    logic             mode_q;
    pat_t             pat_q;

    logic             hc_last, vc_last, first_half, use_broad;
    logic             csync_next, videoen_next;
    sync_t            cls;
    logic [CBITS-1:0] r_n, g_n, b_n;

    always_comb begin
        hc_last    = (hc == H_LAST);
        vc_last    = (vc == (mode_q ? VC_LAST_P : VC_LAST_I));
        first_half = (hc < H_HALF);
        hoff       = first_half ? hc : hc - H_HALF;
        cls        = sync_class(vc, mode_q);
        // Each half-line of a vertical-interval line carries either a broad or an equalising pulse.
        use_broad  = 1'b0;
        case (cls)
            BROAD_BROAD: use_broad = 1'b1;
            BROAD_EQ:    use_broad = first_half;
            EQ_BROAD:    use_broad = !first_half;
            default:     use_broad = 1'b0;
        endcase
        if (cls == VISIBLE)
            csync_next = (hc >= H_SYNC);
        else
            csync_next = (hoff >= (use_broad ? H_BROAD : H_EQ));
        videoen_next = (cls == VISIBLE) && (hc >= H_ACT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc     <= '0;
            vc     <= '0;
            bar    <= '0;
            barsub <= '0;
            mode_q <= 1'b0;
            pat_q  <= PAT_BARS;
        end else begin
            hc <= hc_last ? '0 : hc + HW'(1);
            if (hc_last) begin
                vc <= vc_last ? '0 : vc + 10'd1;
                if (vc_last) begin
                    mode_q <= mode;
                    pat_q  <= pat_t'(pattern);
                end
            end
            // Bar position tracked incrementally from the first active clock.
            if (hc_last) begin
                bar    <= '0;
                barsub <= '0;
            end else if (hc >= H_ACT) begin
                if (barsub == B_LAST) begin
                    barsub <= '0;
                    if (bar != 3'd7)
                        bar <= bar + 3'd1;
                end else begin
                    barsub <= barsub + BW'(1);
                end
            end
        end
    end

    pal_pattern_gen #(.CBITS(CBITS), .BW(BW)) u_pat (
        .pat_q        (pat_q),
        .bar          (bar),
        .barsub       (barsub),
        .vc_lo        (vc[3:0]),
        .videoen_next (videoen_next),
        .r_next       (r_n),
        .g_next       (g_n),
        .b_next       (b_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            csync       <= 1'b1;
            videoen     <= 1'b0;
            field       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r           <= r_n;
            g           <= g_n;
            b           <= b_n;
            csync       <= csync_next;
            videoen     <= videoen_next;
            field       <= !mode_q && (vc >= VC_FIELD2);
            frame_start <= (hc == '0) && (vc == '0);
        end
    end

endmodule

// File: tb/tb_pal_frame_gen.sv
// Scoreboard bench for pal_frame_gen with shortened line timing so whole frames fit the run.
module tb_pal_frame_gen;

    localparam int CB = 4, LC = 24, HC = 12, HS = 2, EQ = 1, BR = 10, AS = 4, BC = 2;
    localparam int FRAME_I = 625 * LC;
    localparam int FRAME_P = 312 * LC;

    typedef struct packed {
        logic [CB-1:0] r, g, b;
        logic cs, ven, fld, fs;
    } out_t;
    typedef struct {
        int   hc;
        int   vc;
        out_t o;
    } exp_t;

    localparam out_t RST_O = '{r: '0, g: '0, b: '0, cs: 1'b1, ven: 1'b0, fld: 1'b0, fs: 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode = 1'b0;
    logic [1:0] pattern = 2'd0;
    logic [CB-1:0] r, g, b;
    logic csync, videoen, field, frame_start;
    out_t obs;

    int total = 0;
    int bad = 0;
    exp_t q[$];

    int m_hc = 0, m_vc = 0;
    bit m_mode = 0;
    bit [1:0] m_pat = 0;

    assign obs = {r, g, b, csync, videoen, field, frame_start};

    always #5 clk = ~clk;

    pal_frame_gen #(
        .CBITS(CB), .LINE_CLKS(LC), .HALF_CLKS(HC), .HSYNC_CLKS(HS), .EQ_CLKS(EQ),
        .BROAD_CLKS(BR), .ACT_START(AS), .BAR_CLKS(BC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .pattern(pattern),
        .r(r), .g(g), .b(b), .csync(csync), .videoen(videoen),
        .field(field), .frame_start(frame_start)
    );

    function automatic out_t model(int hc, int vc, bit mq, bit [1:0] pq);
        out_t o;
        int len, pos, off, bar, sub;
        bit vis, white;
        logic [CB-1:0] F;
        F = '1; o = '0; vis = 0; len = 0; white = 0;
        pos = (hc >= HC) ? hc - HC : hc;
        if (vc inside {0, 1, 313, 314}) len = BR;
        else if (vc == 2) len = (hc >= HC) ? EQ : BR;
        else if (vc == 312) len = (hc >= HC) ? BR : EQ;
        else if ((vc inside {3, 4, 310, 311, 315, 316, 622, 623, 624}) || (mq && vc == 309)) len = EQ;
        else vis = 1;
        o.cs  = vis ? (hc >= HS) : (pos >= len);
        o.ven = vis && (hc >= AS);
        if (o.ven) begin
            off = hc - AS;
            bar = off / BC;
            if (bar > 7) bar = 7;
            sub = off % BC;
            case (pq)
                2'd0: begin
                    o.r = ((bar & 2) == 0) ? F : '0;
                    o.g = (bar < 4) ? F : '0;
                    o.b = ((bar & 1) == 0) ? F : '0;
                end
                2'd1: begin
                    o.r = CB'((bar << 1) | (bar & 1));
                    o.g = o.r;
                    o.b = o.r;
                end
                2'd2: begin
                    white = (sub == 0) || (vc % 16 == 0);
                    o.r = white ? F : '0;
                    o.g = o.r;
                    o.b = o.r;
                end
                default: begin
                    o.r = F; o.g = F; o.b = F;
                end
            endcase
        end
        o.fld = !mq && (vc >= 313);
        o.fs  = (hc == 0) && (vc == 0);
        return o;
    endfunction

    // Reference timing: one expected output per clock edge, tagged with the line position.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.push_back('{hc: -1, vc: -1, o: RST_O});
            m_hc <= 0; m_vc <= 0; m_mode <= 0; m_pat <= 0;
        end else begin
            q.push_back('{hc: m_hc, vc: m_vc, o: model(m_hc, m_vc, m_mode, m_pat)});
            m_hc <= (m_hc == LC - 1) ? 0 : m_hc + 1;
            if (m_hc == LC - 1) begin
                if (m_vc == (m_mode ? 311 : 624)) begin
                    m_vc <= 0; m_mode <= mode; m_pat <= pattern;
                end else begin
                    m_vc <= m_vc + 1;
                end
            end
        end
    end

    task automatic step(output exp_t e);
        @(negedge clk);
        if (q.size() == 0) begin
            e.hc = -2; e.vc = -2; e.o = 'x;
        end else begin
            e = q.pop_front();
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 0; mode = 0; pattern = 2'd0;
        repeat (3) begin
            step(e);
            total++;
            if (obs !== RST_O) begin bad++; $display("FAIL reset_vals got=%h want=%h", obs, RST_O); end
        end
        rst_n = 1;
        step(e);
        total++;
        if (obs.fs !== 1'b1) begin bad++; $display("FAIL first_frame_start got=%b want=1", obs.fs); end
        total++;
        if (obs !== e.o) begin bad++; $display("FAIL sb_reset vc=%0d hc=%0d got=%h want=%h", e.vc, e.hc, obs, e.o); end
    endtask

    task automatic test_bars_frame();
        exp_t e;
        int n = 0, lows0 = 0, lows20 = 0, rise = -1;
        for (int i = 0; i < FRAME_I + 8; i++) begin
            step(e); n++;
            total++;
            if (obs !== e.o) begin bad++; $display("FAIL sb_bars vc=%0d hc=%0d got=%h want=%h", e.vc, e.hc, obs, e.o); end
            if (obs.fs) break;
            if (e.vc == 0) lows0 += !obs.cs;
            if (e.vc == 20) begin
                lows20 += !obs.cs;
                if (obs.ven && rise < 0) rise = e.hc;
                if (e.hc == AS) begin
                    total++;
                    if ({obs.r, obs.g, obs.b} !== 12'hFFF) begin bad++; $display("FAIL bar_white got=%h want=fff", {obs.r, obs.g, obs.b}); end
                end
                if (e.hc == AS + BC) begin
                    total++;
                    if ({obs.r, obs.g, obs.b} !== 12'hFF0) begin bad++; $display("FAIL bar_yellow got=%h want=ff0", {obs.r, obs.g, obs.b}); end
                end
            end
            if (e.vc == 400 && e.hc == 0) begin
                total++;
                if (obs.fld !== 1'b1) begin bad++; $display("FAIL field2 got=%b want=1", obs.fld); end
            end
            if (e.vc == 100 && e.hc == 0) pattern = 2'd1;
        end
        total++;
        if (n !== FRAME_I) begin bad++; $display("FAIL frame_len_i got=%0d want=%0d", n, FRAME_I); end
        // line-0 cycle hc=0 was consumed by the reset test
        total++;
        if (lows0 !== 2 * BR - 1) begin bad++; $display("FAIL line0_broad got=%0d want=%0d", lows0, 2 * BR - 1); end
        total++;
        if (lows20 !== HS) begin bad++; $display("FAIL line20_hsync got=%0d want=%0d", lows20, HS); end
        total++;
        if (rise !== AS) begin bad++; $display("FAIL videoen_rise got=%0d want=%0d", rise, AS); end
    endtask

    task automatic test_ramp_frame();
        exp_t e;
        int n = 0;
        for (int i = 0; i < FRAME_I + 8; i++) begin
            step(e); n++;
            total++;
            if (obs !== e.o) begin bad++; $display("FAIL sb_ramp vc=%0d hc=%0d got=%h want=%h", e.vc, e.hc, obs, e.o); end
            if (obs.fs) break;
            if (e.vc == 10 && e.hc == 0) pattern = 2'd2;
            if (e.vc == 20 && e.hc == AS) begin
                total++;
                if ({obs.r, obs.g, obs.b} !== 12'h000) begin bad++; $display("FAIL ramp_bar0 got=%h want=000", {obs.r, obs.g, obs.b}); end
            end
            if (e.vc == 20 && e.hc == AS + 5 * BC) begin
                total++;
                if ({obs.r, obs.g, obs.b} !== 12'hBBB) begin bad++; $display("FAIL ramp_bar5 got=%h want=bbb", {obs.r, obs.g, obs.b}); end
            end
            if (e.vc == 20 && e.hc == AS + 7 * BC) begin
                total++;
                if ({obs.r, obs.g, obs.b} !== 12'hFFF) begin bad++; $display("FAIL ramp_bar7 got=%h want=fff", {obs.r, obs.g, obs.b}); end
            end
            if (e.vc == 20 && e.hc == LC - 1) begin
                total++;
                if ({obs.r, obs.g, obs.b} !== 12'hFFF) begin bad++; $display("FAIL ramp_saturate got=%h want=fff", {obs.r, obs.g, obs.b}); end
            end
        end
        total++;
        if (n !== FRAME_I) begin bad++; $display("FAIL frame_len_ramp got=%0d want=%0d", n, FRAME_I); end
    endtask

    task automatic test_hatch_frame();
        exp_t e;
        int n = 0, act32 = 0, nw32 = 0, w33 = 0;
        for (int i = 0; i < FRAME_I + 8; i++) begin
            step(e); n++;
            total++;
            if (obs !== e.o) begin bad++; $display("FAIL sb_hatch vc=%0d hc=%0d got=%h want=%h", e.vc, e.hc, obs, e.o); end
            if (obs.fs) break;
            if (e.vc == 32 && obs.ven) begin
                act32++;
                if ({obs.r, obs.g, obs.b} !== 12'hFFF) nw32++;
            end
            if (e.vc == 33 && obs.ven && {obs.r, obs.g, obs.b} === 12'hFFF) w33++;
            if (e.vc == 100 && e.hc == 0) begin mode = 1; pattern = 2'd3; end
        end
        total++;
        if (n !== FRAME_I) begin bad++; $display("FAIL frame_len_switch got=%0d want=%0d", n, FRAME_I); end
        total++;
        if (act32 !== LC - AS || nw32 !== 0) begin bad++; $display("FAIL hatch_line32 active=%0d dark=%0d want %0d/0", act32, nw32, LC - AS); end
        total++;
        if (w33 !== (LC - AS) / BC) begin bad++; $display("FAIL hatch_line33 got=%0d want=%0d", w33, (LC - AS) / BC); end
    endtask

    task automatic test_prog_frame();
        exp_t e;
        int n = 0, flds = 0, lows309 = 0;
        for (int i = 0; i < FRAME_P + 8; i++) begin
            step(e); n++;
            total++;
            if (obs !== e.o) begin bad++; $display("FAIL sb_prog vc=%0d hc=%0d got=%h want=%h", e.vc, e.hc, obs, e.o); end
            if (obs.fs) break;
            flds += obs.fld;
            if (e.vc == 309) lows309 += !obs.cs;
            if (e.vc == 50 && e.hc == AS) begin
                total++;
                if ({obs.r, obs.g, obs.b} !== 12'hFFF) begin bad++; $display("FAIL flat_white got=%h want=fff", {obs.r, obs.g, obs.b}); end
            end
            if (e.vc == 100 && e.hc == 0) mode = 0;
        end
        total++;
        if (n !== FRAME_P) begin bad++; $display("FAIL frame_len_p got=%0d want=%0d", n, FRAME_P); end
        total++;
        if (flds !== 0) begin bad++; $display("FAIL prog_field got=%0d want=0", flds); end
        total++;
        if (lows309 !== 2 * EQ) begin bad++; $display("FAIL line309_eq got=%0d want=%0d", lows309, 2 * EQ); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lows = 0;
        bit found = 0;
        for (int i = 0; i < 401 * LC; i++) begin
            step(e);
            total++;
            if (obs !== e.o) begin bad++; $display("FAIL sb_pre_reset vc=%0d hc=%0d got=%h want=%h", e.vc, e.hc, obs, e.o); end
            if (e.vc == 400 && e.hc == 7) begin found = 1; break; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL reach_vc400 got=0 want=1"); end
        rst_n = 0;
        step(e);
        total++;
        if (obs !== RST_O) begin bad++; $display("FAIL mid_reset_vals got=%h want=%h", obs, RST_O); end
        rst_n = 1;
        step(e);
        total++;
        if (obs.fs !== 1'b1) begin bad++; $display("FAIL restart_frame_start got=%b want=1", obs.fs); end
        lows += !obs.cs;
        for (int i = 1; i < LC; i++) begin
            step(e);
            total++;
            if (obs !== e.o) begin bad++; $display("FAIL sb_restart vc=%0d hc=%0d got=%h want=%h", e.vc, e.hc, obs, e.o); end
            lows += !obs.cs;
        end
        total++;
        if (lows !== 2 * BR) begin bad++; $display("FAIL restart_broad got=%0d want=%0d", lows, 2 * BR); end
    endtask

    initial begin
        test_reset();
        test_bars_frame();
        test_ramp_frame();
        test_hatch_frame();
        test_prog_frame();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
